// File: rtl/bus_pkg.sv
// Shared definitions for the write-side (bus_driver_escritura) and read-side
// (bus_driver_lectura) bus drivers. The peripheral address map lives here so
// both directions decode identically.
package bus_pkg;

  // Peripheral targeted by a bus access. NINGUNO marks an unmapped address.
  typedef enum logic [2:0] {
    NINGUNO,
    RAM,
    TECLADO,
    LED,
    TIMER,
    UART,
    SPI
  } destino_e;

  // Write-side control states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } estado_e;

  // Address map. Limits are inclusive word addresses.
  localparam logic [31:0] RAM_BASE     = 32'h0000_1000;
  localparam logic [31:0] RAM_LIMIT    = 32'h0000_1FFC;
  localparam logic [31:0] TECLADO_ADDR = 32'h0000_2000;
  localparam logic [31:0] LED_ADDR     = 32'h0000_2004;
  localparam logic [31:0] TIMER_ADDR   = 32'h0000_2010;
  localparam logic [31:0] UART_BASE    = 32'h0000_2020;
  localparam logic [31:0] UART_LIMIT   = 32'h0000_202C;
  localparam logic [31:0] SPI_BASE     = 32'h0000_2200;
  localparam logic [31:0] SPI_LIMIT    = 32'h0000_23FC;

  // Busy flag that applies to a given target; only UART and SPI can stall.
  function automatic logic busy_de(destino_e d, logic uart_busy, logic spi_busy);
    case (d)
      UART:    return uart_busy;
      SPI:     return spi_busy;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/decodificador_direccion.sv
// Combinational address decoder shared by the read and write bus drivers.
// Ports:
//   address_i  bus address (bits [1:0] ignored, accesses are word aligned)
//   destino_o  decoded target, NINGUNO when the address is unmapped
module decodificador_direccion
  import bus_pkg::*;
#(
  parameter int ANCHO = 32
) (
  input  logic [ANCHO-1:0] address_i,
  output destino_e         destino_o
);

  logic [ANCHO-1:0] w_palabra;

  // Drop the byte offset so every byte of a word decodes the same way.
  assign w_palabra = address_i & ~ANCHO'(3);

  always_comb begin
    destino_o = NINGUNO;
    if (w_palabra >= ANCHO'(RAM_BASE) && w_palabra <= ANCHO'(RAM_LIMIT))
      destino_o = RAM;
    else if (w_palabra == ANCHO'(TECLADO_ADDR))
      destino_o = TECLADO;
    else if (w_palabra == ANCHO'(LED_ADDR))
      destino_o = LED;
    else if (w_palabra == ANCHO'(TIMER_ADDR))
      destino_o = TIMER;
    else if (w_palabra >= ANCHO'(UART_BASE) && w_palabra <= ANCHO'(UART_LIMIT))
      destino_o = UART;
    else if (w_palabra >= ANCHO'(SPI_BASE) && w_palabra <= ANCHO'(SPI_LIMIT))
      destino_o = SPI;
  end

endmodule

// File: rtl/bus_driver_escritura.sv
// Write-side bus driver between the core data port and the memory-mapped
// peripherals. Accepts one store per cycle, registers address/data, and
// raises a one-cycle write strobe for the decoded target. Stores to a busy
// UART/SPI stall the core until the peripheral frees up or TIMEOUT_CYC
// cycles pass, in which case the store is dropped with err_o.
// Ports:
//   clk_i, rst_n_i          clock, synchronous active-low reset
//   we_i, address_i, data_i core store request
//   uart_busy_i, spi_busy_i peripheral back-pressure
//   stall_o                 core must hold its request
//   err_o                   one-cycle pulse: unmapped store or timeout
//   addr_o, d_o             registered address/data to the peripherals
//   we_*_o                  one-cycle write strobes, at most one high
module bus_driver_escritura
  import bus_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int ANCHO       = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             we_i,
  input  logic [ANCHO-1:0] address_i,
  input  logic [ANCHO-1:0] data_i,
  input  logic             uart_busy_i,
  input  logic             spi_busy_i,
  output logic             stall_o,
  output logic             err_o,
  output logic [ANCHO-1:0] addr_o,
  output logic [ANCHO-1:0] d_o,
  output logic             we_ram_o,
  output logic             we_teclado_o,
  output logic             we_led_o,
  output logic             we_timer_o,
  output logic             we_uart_o,
  output logic             we_spi_o
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC) + 1;

  estado_e          r_estado;
  destino_e         r_destino;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [ANCHO-1:0] r_addr;
  logic [ANCHO-1:0] r_data;

  destino_e w_destino_dec;
  logic     w_busy_dec;
  logic     w_busy_sel;
  logic     w_limite;
  logic     w_issue;

  decodificador_direccion #(
    .ANCHO(ANCHO)
  ) u_dec (
    .address_i(address_i),
    .destino_o(w_destino_dec)
  );

  // Busy of the incoming target decides IDLE/ISSUE -> WAIT; while waiting
  // only the captured target's busy matters.
  assign w_busy_dec = busy_de(w_destino_dec, uart_busy_i, spi_busy_i);
  assign w_busy_sel = busy_de(r_destino, uart_busy_i, spi_busy_i);
  assign w_limite   = (r_cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_estado  <= IDLE;
      r_destino <= NINGUNO;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_addr    <= '0;
      r_data    <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_estado)
        WAIT: begin
          // we_i is ignored here: the core is holding the same store.
          if (!w_busy_sel) begin
            r_estado <= ISSUE;
          end else if (w_limite) begin
            r_estado <= IDLE;
            r_err    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          if (we_i) begin
            r_addr    <= address_i;
            r_data    <= data_i;
            r_destino <= w_destino_dec;
            if (w_destino_dec == NINGUNO) begin
              r_estado <= IDLE;
              r_err    <= 1'b1;
            end else if (w_busy_dec) begin
              r_estado <= WAIT;
              r_cnt    <= '0;
            end else begin
              r_estado <= ISSUE;
            end
          end else begin
            r_estado <= IDLE;
          end
        end
      endcase
    end
  end

  assign w_issue      = (r_estado == ISSUE);
  assign stall_o      = (r_estado == WAIT);
  assign err_o        = r_err;
  assign addr_o       = r_addr;
  assign d_o          = r_data;
  assign we_ram_o     = w_issue && (r_destino == RAM);
  assign we_teclado_o = w_issue && (r_destino == TECLADO);
  assign we_led_o     = w_issue && (r_destino == LED);
  assign we_timer_o   = w_issue && (r_destino == TIMER);
  assign we_uart_o    = w_issue && (r_destino == UART);
  assign we_spi_o     = w_issue && (r_destino == SPI);

endmodule

// File: tb/tb_bus_driver_escritura.sv
module tb_bus_driver_escritura;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        we_i;
  logic [31:0] address_i;
  logic [31:0] data_i;
  logic        uart_busy_i;
  logic        spi_busy_i;
  logic        stall_o;
  logic        err_o;
  logic [31:0] addr_o;
  logic [31:0] d_o;
  logic        we_ram_o, we_teclado_o, we_led_o, we_timer_o, we_uart_o, we_spi_o;

  bus_driver_escritura #(
    .TIMEOUT_CYC(TO),
    .ANCHO(32)
  ) dut (
    .clk_i(clk_i),
    .rst_n_i(rst_n_i),
    .we_i(we_i),
    .address_i(address_i),
    .data_i(data_i),
    .uart_busy_i(uart_busy_i),
    .spi_busy_i(spi_busy_i),
    .stall_o(stall_o),
    .err_o(err_o),
    .addr_o(addr_o),
    .d_o(d_o),
    .we_ram_o(we_ram_o),
    .we_teclado_o(we_teclado_o),
    .we_led_o(we_led_o),
    .we_timer_o(we_timer_o),
    .we_uart_o(we_uart_o),
    .we_spi_o(we_spi_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Target numbering used by the model: 0 none, 1 RAM, 2 teclado, 3 LED,
  // 4 timer, 5 UART, 6 SPI. Bit (n-1) of the strobe vector belongs to n.
  function automatic int decode(input logic [31:0] a);
    int w;
    w = int'(a) & ~3;
    if (w >= 'h1000 && w <= 'h1FFC) return 1;
    if (w == 'h2000) return 2;
    if (w == 'h2004) return 3;
    if (w == 'h2010) return 4;
    if (w >= 'h2020 && w <= 'h202C) return 5;
    if (w >= 'h2200 && w <= 'h23FC) return 6;
    return 0;
  endfunction

  function automatic logic busy_of(input int t, input logic ub, input logic sb);
    return (t == 5) ? ub : (t == 6) ? sb : 1'b0;
  endfunction

  // Transaction-level model: a store is either strobed next cycle, parked
  // waiting on its peripheral, or rejected with an error pulse.
  logic        m_pending = 1'b0;
  int          m_waited  = 0;
  int          m_tgt     = 0;
  int          m_strobe  = 0;
  logic        m_err     = 1'b0;
  logic [31:0] m_addr    = '0;
  logic [31:0] m_data    = '0;
  logic        cmp_en    = 1'b0;

  always @(posedge clk_i) begin
    int t;
    if (!rst_n_i) begin
      m_pending = 1'b0; m_waited = 0; m_tgt = 0; m_strobe = 0;
      m_err = 1'b0; m_addr = '0; m_data = '0;
    end else begin
      m_err = 1'b0;
      m_strobe = 0;
      if (m_pending) begin
        if (!busy_of(m_tgt, uart_busy_i, spi_busy_i)) begin
          m_pending = 1'b0;
          m_strobe = m_tgt;
        end else if (m_waited + 1 == TO) begin
          m_pending = 1'b0;
          m_err = 1'b1;
        end else begin
          m_waited++;
        end
      end else if (we_i) begin
        t = decode(address_i);
        m_addr = address_i;
        m_data = data_i;
        m_tgt = t;
        if (t == 0) m_err = 1'b1;
        else if (busy_of(t, uart_busy_i, spi_busy_i)) begin
          m_pending = 1'b1;
          m_waited = 0;
        end else m_strobe = t;
      end
    end
  end

  logic [5:0] strobes;
  assign strobes = {we_spi_o, we_uart_o, we_timer_o, we_led_o, we_teclado_o, we_ram_o};

  int n_stall = 0, n_uart = 0, n_spi = 0, n_err = 0;

  always @(negedge clk_i) begin
    logic [5:0] exp_str;
    if (cmp_en) begin
      exp_str = (m_strobe == 0) ? 6'd0 : 6'(1 << (m_strobe - 1));
      check("stall", {31'd0, stall_o}, {31'd0, m_pending});
      check("err", {31'd0, err_o}, {31'd0, m_err});
      check("strobes", {26'd0, strobes}, {26'd0, exp_str});
      check("addr", addr_o, m_addr);
      check("data", d_o, m_data);
    end
    if (stall_o === 1'b1) n_stall++;
    if (we_uart_o === 1'b1) n_uart++;
    if (we_spi_o === 1'b1) n_spi++;
    if (err_o === 1'b1) n_err++;
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    int s0, u0, p0, e0;
    rst_n_i = 1'b0; we_i = 1'b1; address_i = 32'h1004; data_i = 32'h385;
    uart_busy_i = 1'b0; spi_busy_i = 1'b0;
    step();
    cmp_en = 1'b1;
    step();
    // 1: reset state, then first store to RAM
    check("rst_strobes", {26'd0, strobes}, 32'd0);
    check("rst_stall", {31'd0, stall_o}, 32'd0);
    check("rst_addr", addr_o, 32'd0);
    check("rst_data", d_o, 32'd0);
    rst_n_i = 1'b1;
    step();
    check("t1_we_ram", {31'd0, we_ram_o}, 32'd1);
    check("t1_addr", addr_o, 32'h1004);
    check("t1_data", d_o, 32'h385);
    // 2: back-to-back stores
    address_i = 32'h2004; data_i = 32'h39; step();
    check("t2_led", {26'd0, strobes}, 32'b000100);
    address_i = 32'h2010; data_i = 32'h4; step();
    check("t2_timer", {26'd0, strobes}, 32'b001000);
    address_i = 32'h2000; data_i = 32'h4A; step();
    check("t2_teclado", {26'd0, strobes}, 32'b000010);
    check("t2_data", d_o, 32'h4A);
    we_i = 1'b0; step();
    // 3: UART busy for 5 cycles, SPI busy toggling is ignored
    s0 = n_stall; u0 = n_uart;
    we_i = 1'b1; address_i = 32'h2024; data_i = 32'h55; uart_busy_i = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      spi_busy_i = ~spi_busy_i;
      step();
    end
    spi_busy_i = 1'b0; uart_busy_i = 1'b0;
    step();
    check("t3_we_uart", {31'd0, we_uart_o}, 32'd1);
    check("t3_data", d_o, 32'h55);
    we_i = 1'b0; step();
    check("t3_stall_cycles", n_stall - s0, 32'd5);
    check("t3_uart_pulses", n_uart - u0, 32'd1);
    // 4: SPI stuck busy, timeout
    s0 = n_stall; p0 = n_spi; e0 = n_err;
    we_i = 1'b1; address_i = 32'h2200; data_i = 32'hFF; spi_busy_i = 1'b1;
    step();
    for (int i = 0; i < 20; i++) begin
      if (stall_o !== 1'b1) break;
      step();
    end
    we_i = 1'b0;
    check("t4_err", {31'd0, err_o}, 32'd1);
    check("t4_stall_low", {31'd0, stall_o}, 32'd0);
    step(); step();
    spi_busy_i = 1'b0;
    step();
    check("t4_stall_cycles", n_stall - s0, 32'd8);
    check("t4_no_spi", n_spi - p0, 32'd0);
    check("t4_err_pulses", n_err - e0, 32'd1);
    // 5: unmapped store then RAM store
    we_i = 1'b1; address_i = 32'h3000; data_i = 32'h1; step();
    check("t5_err", {31'd0, err_o}, 32'd1);
    check("t5_nostrobe", {26'd0, strobes}, 32'd0);
    address_i = 32'h1008; data_i = 32'h7; step();
    check("t5_ram", {31'd0, we_ram_o}, 32'd1);
    check("t5_err_clear", {31'd0, err_o}, 32'd0);
    we_i = 1'b0; step();
    // 6: reset during a UART wait
    u0 = n_uart;
    we_i = 1'b1; address_i = 32'h2028; data_i = 32'hAB; uart_busy_i = 1'b1;
    step(); step();
    check("t6_stall", {31'd0, stall_o}, 32'd1);
    rst_n_i = 1'b0; step();
    check("t6_stall_rst", {31'd0, stall_o}, 32'd0);
    rst_n_i = 1'b1; we_i = 1'b0; uart_busy_i = 1'b0;
    step(); step(); step();
    check("t6_no_uart", n_uart - u0, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/bus_driver_escritura.md
Name: bus_driver_escritura

Overview:
Write-side bus driver between the RISC-V core's data port and the memory-mapped peripherals. It accepts one store per cycle, decodes the address into a one-hot write strobe, and registers address and data for the selected target. It stalls the core while the UART or SPI is busy, and flags stores to unmapped addresses or stores that time out. It is the counterpart of the read multiplexer `bus_driver_lectura` and uses the same address map.

Parameters:
- TIMEOUT_CYC, 1024: maximum cycles a store may wait on a busy UART/SPI before it is dropped with err_o.
- ANCHO, 32: address and data width.

Ports:
- clk_i  in  1  system clock, rising edge
- rst_n_i  in  1  reset, synchronous, active-low
- we_i  in  1  core store request
- address_i  in  32  store address
- data_i  in  32  store data
- uart_busy_i  in  1  UART cannot take a write
- spi_busy_i  in  1  SPI cannot take a write
- stall_o  out  1  core must hold its request
- err_o  out  1  one-cycle pulse: unmapped address or timeout
- addr_o  out  32  registered address to the peripherals
- d_o  out  32  registered data to the peripherals
- we_ram_o, we_teclado_o, we_led_o, we_timer_o, we_uart_o, we_spi_o  out  1 each  one-cycle write strobes

Behaviour:
- Address map (word aligned, address_i[1:0] ignored):
  - RAM 0x1000–0x1FFC
  - teclado 0x2000 (write clears the key-valid flag)
  - LED 0x2004
  - timer 0x2010
  - UART 0x2020–0x202C
  - SPI 0x2200–0x23FC
  - anything else is unmapped.
- Acceptance: a store is accepted on any rising edge where we_i=1 and stall_o=0. On acceptance, address_i, data_i and the decoded target are captured into addr_o, d_o and an internal target register.
- stall_o = (state==WAIT). It is combinational from state only, with no path from we_i.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE/ISSUE, no accept → IDLE.
  - IDLE/ISSUE, accept, target mapped and (target not UART/SPI, or its busy_i=0) → ISSUE.
  - IDLE/ISSUE, accept, target UART/SPI with its busy_i=1 → WAIT. The wait counter clears to 0.
  - IDLE/ISSUE, accept, target unmapped → IDLE. err_o=1 on the next cycle; no strobe.
  - WAIT, target busy_i=0 → ISSUE.
  - WAIT, busy_i=1 and counter==TIMEOUT_CYC-1 → IDLE. err_o=1 on the next cycle; the store is dropped.
  - WAIT, otherwise: stay in WAIT, counter+1.
- Strobes: we_X_o = (state==ISSUE) & target==X. At most one strobe is high in any cycle. Latency is exactly 1 cycle from accept to strobe when not waiting.
- Throughput: back-to-back stores to non-busy targets strobe on consecutive cycles. addr_o/d_o change only on acceptance, so they hold stable through the whole WAIT→ISSUE sequence.
- busy_i sampling: busy of the captured target only is sampled each WAIT cycle. Busy of the non-selected peripheral is ignored.
- Counter: $clog2(TIMEOUT_CYC)+1 bits, no wrap; it saturates by construction because the timeout exits WAIT.
- Reset (rst_n_i=0 at a rising edge), including mid-WAIT:
  - state=IDLE, all strobes=0, stall_o=0, err_o=0, addr_o=0, d_o=0, counter=0, target=none
  - any pending store is discarded.
- we_i held high during WAIT is not a new request; the core keeps the same store presented until stall_o falls.

Decomposition:
- Package bus_pkg:
  - typedef enum logic [2:0] destino_e {NINGUNO, RAM, TECLADO, LED, TIMER, UART, SPI}
  - base/limit localparams for each region, shared with bus_driver_lectura
  - state enum estado_e.
- Sub-module decodificador_direccion: combinational address_i → destino_e. It is reusable by the read side.

Test Plan:
1. Reset with we_i=1, address_i=0x1004 → all strobes 0, stall_o=0, addr_o=d_o=0. After release, accept → next cycle we_ram_o=1, addr_o=0x1004, d_o=0x385.
2. Back-to-back stores: 0x2004/0x39, 0x2010/0x4, 0x2000/0x4A on consecutive cycles → we_led_o, we_timer_o, we_teclado_o each high exactly one cycle, in order, stall_o=0 throughout.
3. Store 0x2024/0x55 with uart_busy_i=1 for 5 cycles → stall_o=1 for 5 cycles, then we_uart_o=1 for one cycle with d_o=0x55. A spi_busy_i toggle during the wait has no effect.
4. Store 0x2200/0xFF with spi_busy_i stuck at 1, TIMEOUT_CYC=8 → stall_o high 8 cycles, then err_o one-cycle pulse, we_spi_o never asserts, state returns to IDLE.
5. Store to 0x3000 → err_o pulse next cycle, no strobe, stall_o=0. An immediately following store to 0x1008 strobes we_ram_o normally.
6. rst_n_i=0 during a UART WAIT → next cycle stall_o=0, no we_uart_o even after uart_busy_i falls.
